// File: rtl/demux_merge_pkg.sv
// Shared constants and the tagged FIFO entry for the ALU/Buffer2 merge stage.
package demux_merge_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic OP_ALU  = 1'b0;
  localparam logic OP_BUF2 = 1'b1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/merge_fifo.sv
// DEPTH-entry synchronous FIFO of tagged words; head entry is read combinationally.
module merge_fifo
  import demux_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Gate the head with empty so an idle output reads as all zeros.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_merge.sv
// Round-robin merge of the ALU and Buffer2 result paths into a tagged output FIFO.
module demux_merge
  import demux_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] buf2_data,
  input  logic              buf2_valid,
  output logic              buf2_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     cnt_alu,
  output logic [CW-1:0]     cnt_buf2
);

  logic   last_grant;
  logic   grant;
  logic   space;
  logic   alu_fire;
  logic   buf2_fire;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  entry_t wdata;
  entry_t rdata;

  // On conflict the source that did not win last time is granted.
  always_comb begin
    grant = OP_ALU;
    if (alu_valid && buf2_valid) grant = ~last_grant;
    else if (buf2_valid)         grant = OP_BUF2;
  end

  assign space      = !full;
  assign alu_ready  = space && alu_valid  && (grant == OP_ALU);
  assign buf2_ready = space && buf2_valid && (grant == OP_BUF2);
  assign alu_fire   = alu_valid  && alu_ready;
  assign buf2_fire  = buf2_valid && buf2_ready;
  assign push       = alu_fire || buf2_fire;
  assign pop        = out_valid && out_ready;

  assign wdata.op   = grant;
  assign wdata.data = (grant == OP_BUF2) ? buf2_data : alu_data;

  merge_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = rdata.data;
  assign out_op    = rdata.op;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OP_BUF2;
      cnt_alu    <= '0;
      cnt_buf2   <= '0;
    end else begin
      if (push)      last_grant <= grant;
      if (alu_fire)  cnt_alu    <= cnt_alu + CW'(1);
      if (buf2_fire) cnt_buf2   <= cnt_buf2 + CW'(1);
    end
  end

endmodule

// File: tb/tb_demux_merge.sv
// Bench for demux_merge: directed scenarios plus random traffic against a queue model.
module tb_demux_merge;
  import demux_merge_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] buf2_data;
  logic              buf2_valid;
  logic              buf2_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_op;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     cnt_alu;
  logic [CW-1:0]     cnt_buf2;

  int total = 0;
  int bad   = 0;

  // reference model state
  entry_t q[$];
  bit     m_last;
  int     m_cnt_a;
  int     m_cnt_b;

  demux_merge #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_data   (alu_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .buf2_data  (buf2_data),
    .buf2_valid (buf2_valid),
    .buf2_ready (buf2_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_alu    (cnt_alu),
    .cnt_buf2   (cnt_buf2)
  );

  always #5 clk = ~clk;

  function automatic bit m_gnt(input bit is_buf2, input bit av, input bit bv);
    if (q.size() >= DEPTH) return 1'b0;
    if (av && bv) return is_buf2 ? (m_last == 1'b0) : (m_last == 1'b1);
    return is_buf2 ? bv : av;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; alu_valid = 1'b0; buf2_valid = 1'b0; out_ready = 1'b0;
    alu_data = '0; buf2_data = '0;
    next_cycle();
    rst = 1'b0;
    q.delete(); m_last = 1'b1; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; alu_data = $urandom; buf2_valid = 1'b0; out_ready = 1'b0;
    next_cycle(); next_cycle();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (out_op !== 1'b0) begin bad++; $display("FAIL reset_op got=%0b want=0", out_op); end
    total++; if (cnt_alu !== 4'd0 || cnt_buf2 !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt_alu, cnt_buf2); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", alu_ready); end
    rst = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    alu_data = 32'hDEADBEEF; alu_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", alu_ready); end
    next_cycle();
    alu_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_op !== OP_ALU)
      begin bad++; $display("FAIL single_out got=%0b/%h/%0b want=1/deadbeef/0", out_valid, out_data, out_op); end
    total++; if (cnt_alu !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", cnt_alu); end
    next_cycle(); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [8];
    bit a_acc, b_acc;
    exp_d = '{32'h1, 32'hA, 32'h2, 32'hB, 32'h3, 32'hC, 32'h4, 32'hD};
    do_reset();
    out_ready = 1'b1;
    alu_data = 32'h1; buf2_data = 32'hA; alu_valid = 1'b1; buf2_valid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      a_acc = alu_ready; b_acc = buf2_ready;
      total++; if ((a_acc ^ b_acc) !== 1'b1) begin bad++; $display("FAIL b2b_onehot cyc=%0d got=%0b%0b want=one", i, a_acc, b_acc); end
      next_cycle();
      if (a_acc) alu_data = alu_data + 32'd1;
      if (b_acc) buf2_data = buf2_data + 32'd1;
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_op !== 1'(i % 2))
        begin bad++; $display("FAIL b2b_out cyc=%0d got=%0b/%h/%0b want=1/%h/%0b", i, out_valid, out_data, out_op, exp_d[i], i % 2); end
    end
    total++; if (cnt_alu !== 4'd4 || cnt_buf2 !== 4'd4) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d want=4/4", cnt_alu, cnt_buf2); end
    alu_valid = 1'b0; buf2_valid = 1'b0;
    next_cycle(); next_cycle();
  endtask

  task automatic test_full();
    do_reset();
    alu_data = 32'h11; alu_valid = 1'b1;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL full_r1 got=%0b want=1", alu_ready); end
    next_cycle();
    alu_data = 32'h22;
    #1;
    total++; if (alu_ready !== 1'b1 || out_data !== 32'h11) begin bad++; $display("FAIL full_r2 got=%0b/%h want=1/11", alu_ready, out_data); end
    next_cycle();
    alu_data = 32'h44; buf2_data = 32'h33; buf2_valid = 1'b1;
    #1;
    total++; if (alu_ready !== 1'b0 || buf2_ready !== 1'b0) begin bad++; $display("FAIL full_low got=%0b%0b want=00", alu_ready, buf2_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (alu_ready !== 1'b0 || buf2_ready !== 1'b0 || out_data !== 32'h11)
      begin bad++; $display("FAIL full_nopass got=%0b%0b/%h want=00/11", alu_ready, buf2_ready, out_data); end
    next_cycle(); #1;
    total++; if (buf2_ready !== 1'b1 || alu_ready !== 1'b0 || out_data !== 32'h22)
      begin bad++; $display("FAIL full_reopen got=%0b%0b/%h want=01/22", alu_ready, buf2_ready, out_data); end
    next_cycle();
    buf2_valid = 1'b0;
    #1;
    total++; if (out_data !== 32'h33 || out_op !== OP_BUF2) begin bad++; $display("FAIL full_order got=%h/%0b want=33/1", out_data, out_op); end
    alu_valid = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_hold();
    int seen = 0;
    do_reset();
    out_ready = 1'b1;
    buf2_data = 32'h55; buf2_valid = 1'b1;
    alu_data = 32'h100; alu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 1) begin
        total++; if (buf2_ready !== 1'b1) begin bad++; $display("FAIL hold_grant got=%0b want=1", buf2_ready); end
      end
      if (out_valid && out_op == OP_BUF2 && out_data == 32'h55) seen++;
      if (buf2_ready) begin next_cycle(); buf2_valid = 1'b0; end
      else next_cycle();
      alu_data = alu_data + 32'd1;
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL hold_once got=%0d want=1", seen); end
    alu_valid = 1'b0;
    next_cycle(); next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    alu_valid = 1'b1; alu_data = 32'h71;
    next_cycle();
    alu_data = 32'h72;
    next_cycle();
    rst = 1'b1; buf2_valid = 1'b1; buf2_data = 32'h73; out_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || cnt_alu !== 4'd0 || cnt_buf2 !== 4'd0)
      begin bad++; $display("FAIL rstmid_clear got=%0b/%0d/%0d want=0/0/0", out_valid, cnt_alu, cnt_buf2); end
    total++; if (alu_ready !== 1'b1 || buf2_ready !== 1'b0)
      begin bad++; $display("FAIL rstmid_grant got=%0b%0b want=10", alu_ready, buf2_ready); end
    alu_valid = 1'b0; buf2_valid = 1'b0;
    next_cycle(); next_cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      alu_data = $urandom;
      next_cycle();
    end
    alu_valid = 1'b0;
    #1;
    total++; if (cnt_alu !== 4'd1 || cnt_buf2 !== 4'd0) begin bad++; $display("FAIL wrap_cnt got=%0d/%0d want=1/0", cnt_alu, cnt_buf2); end
    next_cycle();
  endtask

  task automatic test_random();
    bit a_pend = 0, b_pend = 0, ga, gb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin a_pend = 1; alu_data = $urandom; end
      if (!b_pend && $urandom_range(0, 3) != 0) begin b_pend = 1; buf2_data = $urandom; end
      alu_valid = a_pend; buf2_valid = b_pend;
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      ga = m_gnt(0, a_pend, b_pend);
      gb = m_gnt(1, a_pend, b_pend);
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (out_data !== q[0].data || out_op !== q[0].op)
          begin bad++; $display("FAIL rnd_head cyc=%0d got=%h/%0b want=%h/%0b", i, out_data, out_op, q[0].data, q[0].op); end
      end
      total++; if (cnt_alu !== CW'(m_cnt_a) || cnt_buf2 !== CW'(m_cnt_b))
        begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, cnt_alu, cnt_buf2, CW'(m_cnt_a), CW'(m_cnt_b)); end
      if (a_pend) begin
        total++; if (alu_ready !== ga) begin bad++; $display("FAIL rnd_alu_ready cyc=%0d got=%0b want=%0b", i, alu_ready, ga); end
      end
      if (b_pend) begin
        total++; if (buf2_ready !== gb) begin bad++; $display("FAIL rnd_buf2_ready cyc=%0d got=%0b want=%0b", i, buf2_ready, gb); end
      end
      @(posedge clk);
      if (rst) begin
        q.delete(); m_last = 1'b1; m_cnt_a = 0; m_cnt_b = 0;
      end else begin
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (ga) begin q.push_back('{op: OP_ALU, data: alu_data}); m_last = OP_ALU; m_cnt_a = (m_cnt_a + 1) % 16; a_pend = 0; end
        if (gb) begin q.push_back('{op: OP_BUF2, data: buf2_data}); m_last = OP_BUF2; m_cnt_b = (m_cnt_b + 1) % 16; b_pend = 0; end
      end
      @(negedge clk);
    end
    rst = 1'b0; alu_valid = 1'b0; buf2_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; buf2_valid = 1'b0; out_ready = 1'b0;
    alu_data = '0; buf2_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
